// File: rtl/mbr_hs.sv
// Memory buffer register with a req/ack memory handshake, busy/done status and ack timeout.
// Optional read/write parity checking is compiled in with `define MBR_PARITY_EN.
module mbr_hs #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 8,
  parameter int ADDR_W = 8,
  parameter int TMO_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        control,
  input  logic              start,
  input  logic [DATA_W-1:0] from_acc,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
`ifdef MBR_PARITY_EN
  input  logic              mem_rpar,
  output logic              mem_wpar,
  output logic              par_err,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] to_memory,
  output logic [DATA_W-1:0] to_br,
  output logic [ADDR_W-1:0] addr_out,
  output logic [OP_W-1:0]   to_ir,
  output logic              imm,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [1:0] CMD_FETCH = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_STORE = 2'b11;
  // Counter value on the last REQ cycle before it would reach 2^TMO_W-1.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t            state_q, state_d;
  logic [1:0]        cmd_q;
  logic [TMO_W-1:0]  cnt_q;
  logic              err_q;
  logic              launch, ack_fire, tmo, par_ok, cap;

  function automatic logic even_par(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  assign launch   = (state_q == S_IDLE) && start && (control != 2'b00);
  assign ack_fire = (state_q == S_REQ) && mem_ack;
  assign tmo      = (state_q == S_REQ) && !mem_ack && (cnt_q == TMO_LAST);

`ifdef MBR_PARITY_EN
  logic par_err_q;
  assign par_ok   = (cmd_q == CMD_STORE) || (even_par(mem_rdata) == mem_rpar);
  assign mem_wpar = even_par(to_memory);
  assign par_err  = par_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= ack_fire && !par_ok;
  end
`else
  assign par_ok = 1'b1;
`endif

  assign cap = ack_fire && par_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_REQ;
      S_REQ: begin
        if (mem_ack)  state_d = S_DONE;
        else if (tmo) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == S_REQ);
    busy    = (state_q == S_REQ);
    mem_we  = (state_q == S_REQ) && (cmd_q == CMD_STORE);
    done    = (state_q == S_DONE);
    err     = err_q;
  end

  // Command latch, timeout counter and datapath capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q     <= 2'b00;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      to_memory <= '0;
      to_br     <= '0;
      addr_out  <= '0;
      to_ir     <= '0;
      imm       <= 1'b0;
    end else begin
      err_q <= tmo;
      if (launch) begin
        cmd_q <= control;
        cnt_q <= '0;
        if (control == CMD_STORE) to_memory <= from_acc;
      end else if ((state_q == S_REQ) && !mem_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (cap) begin
        case (cmd_q)
          CMD_FETCH: begin
            to_ir <= mem_rdata[DATA_W-1:ADDR_W];
            if (mem_rdata[DATA_W-1]) begin
              to_br <= {{(DATA_W-ADDR_W){1'b0}}, mem_rdata[ADDR_W-1:0]};
              imm   <= 1'b1;
            end else begin
              addr_out <= mem_rdata[ADDR_W-1:0];
              imm      <= 1'b0;
            end
          end
          CMD_LOAD: to_br <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mbr_hs.sv
// Directed table-driven bench for mbr_hs with hand sequences for reset and parity corners.
module tb_mbr_hs;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  control;
  logic        start;
  logic [15:0] from_acc, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, imm, busy, done, err;
  logic [15:0] to_memory, to_br;
  logic [7:0]  addr_out, to_ir;
`ifdef MBR_PARITY_EN
  logic mem_rpar, mem_wpar, par_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mbr_hs #(.DATA_W(16), .OP_W(8), .ADDR_W(8), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .control(control), .start(start),
    .from_acc(from_acc), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef MBR_PARITY_EN
    .mem_rpar(mem_rpar), .mem_wpar(mem_wpar), .par_err(par_err),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .to_memory(to_memory), .to_br(to_br),
    .addr_out(addr_out), .to_ir(to_ir), .imm(imm), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  ctrl;
    logic [15:0] acc;
    logic [15:0] rd;
    int          ack_after;
    bit          poke;
    logic [7:0]  ir;
    logic [7:0]  addr;
    logic [15:0] br;
    logic [15:0] tm;
    logic        imm;
    int          req;
    int          we;
    bit          dn;
    bit          er;
  } vec_t;

  // Issues one command; ack_after = REQ cycles waited before ack (-1: never).
  task automatic run_cmd(input logic [1:0] ctrl, input logic [15:0] acc, input logic [15:0] rd,
                         input int ack_after, input bit poke, input bit bad_par,
                         output int req_cyc, output int we_cyc, output bit got_done,
                         output bit got_err, output bit got_perr);
    req_cyc = 0; we_cyc = 0; got_done = 0; got_err = 0; got_perr = 0;
    @(negedge clk);
    control = ctrl; from_acc = acc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        got_done = 1;
`ifdef MBR_PARITY_EN
        got_perr = par_err;
`endif
      end
      if (err) got_err = 1;
      if (mem_req) begin
        req_cyc++;
        if (mem_we) we_cyc++;
      end
      if (got_done || got_err) break;
      start   = poke && (req_cyc == 2);
      control = (poke && req_cyc == 2) ? 2'b01 : control;
      if (mem_req && ack_after >= 0 && (req_cyc - 1) == ack_after) begin
        mem_ack = 1'b1; mem_rdata = rd;
`ifdef MBR_PARITY_EN
        mem_rpar = (^rd) ^ bad_par;
`endif
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[9];
  int   rq, wq;
  bit   dn, er, pe;

  initial begin
    vecs[0] = '{2'b01, 16'h0000, 16'h1234,  0, 0, 8'h12, 8'h34, 16'h0000, 16'h0000, 1'b0,  1, 0, 1, 0};
    vecs[1] = '{2'b01, 16'h0000, 16'h85A7,  0, 0, 8'h85, 8'h34, 16'h00A7, 16'h0000, 1'b1,  1, 0, 1, 0};
    vecs[2] = '{2'b10, 16'h0000, 16'hCAFE,  1, 0, 8'h85, 8'h34, 16'hCAFE, 16'h0000, 1'b1,  2, 0, 1, 0};
    vecs[3] = '{2'b11, 16'hBEEF, 16'h5555,  3, 1, 8'h85, 8'h34, 16'hCAFE, 16'hBEEF, 1'b1,  4, 4, 1, 0};
    vecs[4] = '{2'b10, 16'h0000, 16'h1111, -1, 0, 8'h85, 8'h34, 16'hCAFE, 16'hBEEF, 1'b1, 15, 0, 0, 1};
    vecs[5] = '{2'b10, 16'h0000, 16'h0F0F,  0, 0, 8'h85, 8'h34, 16'h0F0F, 16'hBEEF, 1'b1,  1, 0, 1, 0};
    vecs[6] = '{2'b01, 16'h0000, 16'h7F01,  2, 0, 8'h7F, 8'h01, 16'h0F0F, 16'hBEEF, 1'b0,  3, 0, 1, 0};
    vecs[7] = '{2'b00, 16'h0000, 16'hFFFF, -1, 0, 8'h7F, 8'h01, 16'h0F0F, 16'hBEEF, 1'b0,  0, 0, 0, 0};
    vecs[8] = '{2'b01, 16'h0000, 16'h9955, 14, 0, 8'h99, 8'h01, 16'h0055, 16'hBEEF, 1'b1, 15, 0, 1, 0};

    rst_n = 1'b0; control = 2'b01; start = 1'b1; from_acc = 16'hFFFF;
    mem_rdata = 16'h0; mem_ack = 1'b0;
`ifdef MBR_PARITY_EN
    mem_rpar = 1'b0;
`endif
    // Reset held with a start request present
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_outs", {mem_we, imm, busy, done, err, to_ir, addr_out}, 0);
      chk("rst_data", {to_memory, to_br}, 0);
`ifdef MBR_PARITY_EN
      chk("rst_par_err", par_err, 0);
`endif
    end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a request aborts it silently
    control = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_req_up", mem_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_req", mem_req, 0);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("mid_rst_nodone", {done, err, busy}, 0);
    chk("mid_rst_ir", to_ir, 0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].ctrl, vecs[i].acc, vecs[i].rd, vecs[i].ack_after, vecs[i].poke, 1'b0,
              rq, wq, dn, er, pe);
      chk($sformatf("v%0d_req_cycles", i), rq, vecs[i].req);
      chk($sformatf("v%0d_we_cycles", i), wq, vecs[i].we);
      chk($sformatf("v%0d_done", i), dn, vecs[i].dn);
      chk($sformatf("v%0d_err", i), er, vecs[i].er);
      chk($sformatf("v%0d_to_ir", i), to_ir, vecs[i].ir);
      chk($sformatf("v%0d_addr_out", i), addr_out, vecs[i].addr);
      chk($sformatf("v%0d_to_br", i), to_br, vecs[i].br);
      chk($sformatf("v%0d_to_memory", i), to_memory, vecs[i].tm);
      chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
      chk($sformatf("v%0d_idle_after", i), {mem_req, busy, done, err}, 0);
    end

`ifdef MBR_PARITY_EN
    // Bad read parity blocks the capture, good parity allows it
    run_cmd(2'b10, 16'h0, 16'h0001, 0, 0, 1'b1, rq, wq, dn, er, pe);
    chk("par_bad_done", dn, 1);
    chk("par_bad_flag", pe, 1);
    chk("par_bad_br", to_br, 16'h0055);
    run_cmd(2'b10, 16'h0, 16'h0001, 0, 0, 1'b0, rq, wq, dn, er, pe);
    chk("par_ok_done", dn, 1);
    chk("par_ok_flag", pe, 0);
    chk("par_ok_br", to_br, 16'h0001);
    chk("wpar", mem_wpar, ^16'hBEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mbr_hs.md
Name: mbr_hs

Overview:
- Parametrised memory buffer register with a req/ack handshake to memory.
- Sits between the memory port and the CPU datapath: instruction register, buffer register, address path and accumulator.
- Executes one command per start strobe: instruction fetch with immediate decode, operand load, or accumulator store.
- Adds busy/done status and an ack timeout, which the previous fixed-16-bit MBR lacked.

Parameters:
- DATA_W, 16: memory word width; must equal OP_W + ADDR_W.
- OP_W, 8: opcode field width, taken from the upper bits of the word.
- ADDR_W, 8: address/immediate field width, taken from the lower bits of the word.
- TMO_W, 4: timeout counter width; a request aborts after 2^TMO_W-1 cycles without ack.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- control  input  2  command: 00 none, 01 fetch, 10 load, 11 store.
- start  input  1  command strobe; sampled only in IDLE.
- from_acc  input  DATA_W  accumulator value to be stored.
- mem_rdata  input  DATA_W  memory read data; valid while mem_ack=1.
- mem_ack  input  1  memory acknowledge.
- mem_req  output  1  memory request, registered.
- mem_we  output  1  write enable; qualifies mem_req.
- to_memory  output  DATA_W  write data to memory.
- to_br  output  DATA_W  buffer register value.
- addr_out  output  ADDR_W  operand address.
- to_ir  output  OP_W  instruction register opcode.
- imm  output  1  last fetch was immediate.
- busy  output  1  transaction outstanding.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle timeout pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset: state=IDLE, timeout counter=0. All outputs 0: mem_req, mem_we, to_memory, to_br, addr_out, to_ir, imm, busy, done, err.
- Reset mid-transaction: aborts the transaction; mem_req is low from the next edge; no done or err pulse.
- States: IDLE, REQ, DONE.
- IDLE, start=1, control!=00:
  - Latch control into cmd_q.
  - If control=11, also latch to_memory<=from_acc.
  - Next state REQ with mem_req=1, mem_we=(control==11), busy=1, counter cleared.
- IDLE, start=1, control=00: no-op; remain in IDLE, no done pulse.
- mem_ack in IDLE or DONE: ignored.
- REQ, mem_ack=1: capture by cmd_q, then mem_req<=0, busy<=0, go to DONE.
  - Fetch (01): to_ir<=mem_rdata[DATA_W-1:ADDR_W].
  - Fetch, mem_rdata[DATA_W-1]=1: to_br<=zero-extended mem_rdata[ADDR_W-1:0], imm<=1; addr_out unchanged.
  - Fetch, mem_rdata[DATA_W-1]=0: addr_out<=mem_rdata[ADDR_W-1:0], imm<=0; to_br unchanged.
  - Load (10): to_br<=mem_rdata; to_ir, addr_out and imm unchanged.
  - Store (11): no capture; to_memory holds its value.
- REQ, mem_ack=0: counter increments.
  - When counter reaches 2^TMO_W-1: err=1 for one cycle, mem_req<=0, busy<=0, go to IDLE.
  - No datapath register updates on timeout.
  - Ack in the same cycle the counter reaches max: ack wins.
- DONE: done=1 for exactly one cycle, then IDLE. start during DONE is ignored.
- start while busy: ignored; no queueing.
- Latency: start sampled at edge 0 → mem_req high after edge 0. Ack during the first REQ cycle → capture at edge 1, done high after edge 1.
- Minimum start-to-start period: 3 cycles.
- Output holding: to_br, addr_out, to_ir and imm hold between commands. mem_we is only meaningful while mem_req=1.

Optional Feature:
MBR_PARITY_EN
- Defined:
  - Adds ports mem_rpar (input, 1), mem_wpar (output, 1), par_err (output, 1).
  - mem_wpar = even parity (XOR reduce) of to_memory.
  - On ack of fetch or load: if XOR of mem_rdata != mem_rpar, par_err=1 together with done, and no datapath register is updated.
  - par_err resets to 0.
- Undefined: these ports and all parity logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with start=1, control=01 → all outputs 0, mem_req never asserts.
- Fetch, direct: control=01, start pulse; ack one cycle later with mem_rdata=16'h1234 → to_ir=8'h12, addr_out=8'h34, imm=0, to_br unchanged; done pulse 2 edges after start.
- Fetch, immediate: mem_rdata=16'h85A7 → to_ir=8'h85, to_br=16'h00A7, imm=1, addr_out unchanged.
- Store with delay: from_acc=16'hBEEF, start; ack after 3 wait cycles → mem_req=1 and mem_we=1 for 4 cycles, to_memory=16'hBEEF; a second start during REQ is ignored.
- Timeout: control=10, never ack → err pulse after 15 REQ cycles, busy=0, to_br unchanged, no done. A following load acked with 16'h0F0F gives to_br=16'h0F0F.
- Parity (MBR_PARITY_EN): load, mem_rdata=16'h0001, mem_rpar=0 → par_err=1 with done, to_br unchanged. Repeat with mem_rpar=1 → to_br=16'h0001, par_err=0.
